fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and issues word-aligned read requests to instruction memory over a valid/ready request channel. It buffers in-order responses in a small FIFO tagged with their PC and presents them to decode over a valid/ready handshake. A redirect from execute (branch/jump) flushes buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, instruction buffer entries; power of two, ≥2; also the cap on in-flight plus buffered requests
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  request address (= fetch_pc, bits [1:0] always 0)
- imem_resp_valid  input  1  response valid; responses return in request order, ≥1 cycle after acceptance
- imem_resp_data  input  32  fetched instruction word
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0)
- instr_valid  output  1  instruction available to decode
- instr_ready  input  1  decode consumes instruction this cycle
- instruction  output  32  instruction word at buffer head
- instr_pc  output  32  PC of that instruction

## Operation
- State: fetch_pc (32), resp_pc (32), inflight counter, drop counter, DEPTH-entry ring buffer of {pc, instruction} with head/tail/count. Counters are $clog2(DEPTH)+1 bits wide.
- Request issue: imem_req_valid = !redirect_valid && (inflight + count < DEPTH). On accept (valid && ready): fetch_pc += 4 (wraps modulo 2^32), inflight += 1.
- Response: each imem_resp_valid decrements inflight. If drop > 0: drop -= 1 and the word is discarded. Otherwise {resp_pc, data} is pushed at tail and resp_pc += 4.
- Credit rule guarantees a push never meets a full buffer; no overflow path exists.
- Output: instr_valid = (count != 0) && !redirect_valid; instruction/instr_pc = head entry. A pop occurs on instr_valid && instr_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (highest priority): fetch_pc and resp_pc ← {redirect_pc[31:2], 2'b00}; buffer count/head/tail ← 0; drop ← inflight − (imem_resp_valid ? 1 : 0); inflight updated as normal. No request is issued and no pop occurs in the redirect cycle. Any response arriving that cycle is discarded.
- Back-to-back redirects: the later one wins; the drop count is recomputed each time from inflight.
- Responses with inflight == 0 are illegal memory behaviour and need not be handled.

## Timing
- Reset (synchronous, checked at clock edge): fetch_pc = resp_pc = RESET_PC, inflight = drop = count = 0. In the cycle reset is high: imem_req_valid = 0, instr_valid = 0. imem_req_addr = RESET_PC in the first cycle after reset deasserts. instruction/instr_pc contents are don't-care while instr_valid = 0.
- Reset mid-operation discards all buffered and in-flight state. Memory must also be reset, so late responses do not occur.
- Latency: request accepted in cycle N, response in cycle N+k (k ≥ 1), instr_valid in cycle N+k+1 (buffer write is registered; no bypass).
- Throughput: with k = 1, imem_req_ready = 1 and instr_ready = 1, one instruction per cycle is sustained after a 2-cycle fill.
- Redirect penalty: first request to redirect_pc is issued in the cycle after redirect_valid.
- imem_req_addr is held stable while imem_req_valid && !imem_req_ready.

## Test plan
- Reset, RESET_PC = 32'h100, memory latency 1, always ready → requests 0x100, 0x104, 0x108… on consecutive cycles; instr_pc 0x100 appears 2 cycles after reset release, then one per cycle in order with matching data.
- instr_ready held 0 → exactly DEPTH (4) requests issued, instr_valid = 1 with head PC 0x100 stable, imem_req_valid = 0. Raising instr_ready resumes one request per pop.
- Memory latency 3, redirect to 32'h2002 while 2 requests are in flight → both returning words are dropped; next request addr = 32'h2000; first delivered instr_pc = 32'h2000.
- Redirect in the same cycle as a response and a decode handshake → response discarded, no pop counted, instr_valid = 0 that cycle, buffer empty next cycle.
- imem_req_ready toggling 1/0 randomly → imem_req_addr stable while stalled; delivered PCs strictly sequential with no duplicates or gaps.
- fetch_pc = 32'hFFFF_FFFC → next request address wraps to 32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and decode hand-off.
// The fetch unit takes the master view; memory, execute and decode together take the slave view.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited memory requests, buffers in-order
// responses tagged with their PC, and flushes/restarts on a redirect from execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   respPc_q, respPc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   bufPc_q   [DEPTH];
  logic [31:0]   bufData_q [DEPTH];

  logic [CW:0]   occupancy;
  logic [31:0]   redirectPc;
  logic          reqValid;
  logic          reqFire;
  logic          instrValid;
  logic          push;
  logic          pop;

  // In-flight plus buffered words never exceed DEPTH, so a push always finds a free slot.
  always_comb begin
    redirectPc = {bus.redirect_pc[31:2], 2'b00};
    occupancy  = {1'b0, inflight_q} + {1'b0, count_q};
    reqValid   = !reset && !bus.redirect_valid && (occupancy < (CW+1)'(DEPTH));
    reqFire    = reqValid && bus.imem_req_ready;
    instrValid = !reset && !bus.redirect_valid && (count_q != '0);
    pop        = instrValid && bus.instr_ready;
    push       = bus.imem_resp_valid && !bus.redirect_valid && (drop_q == '0);
  end

  always_comb begin
    inflight_d = inflight_q + CW'(reqFire) - CW'(bus.imem_resp_valid);
    drop_d     = drop_q;
    fetchPc_d  = fetchPc_q;
    respPc_d   = respPc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (bus.redirect_valid) begin
      // Words still owed by memory belong to the old path; the one arriving now is already gone.
      drop_d    = inflight_q - CW'(bus.imem_resp_valid);
      fetchPc_d = redirectPc;
      respPc_d  = redirectPc;
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
    end else begin
      if (bus.imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (reqFire) begin
        fetchPc_d = fetchPc_q + 32'd4;
      end
      if (push) begin
        respPc_d = respPc_q + 32'd4;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q  <= RESET_PC;
      respPc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      respPc_q   <= respPc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      bufPc_q[tail_q]   <= respPc_q;
      bufData_q[tail_q] <= bus.imem_resp_data;
    end
  end

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = fetchPc_q;
  assign bus.instr_valid    = instrValid;
  assign bus.instruction    = bufData_q[head_q];
  assign bus.instr_pc       = bufPc_q[head_q];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fixed-latency memory model feeds it, and a scoreboard checks
// every accepted request address and every delivered {pc, instruction} pair in program order.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          nVectors;
  int          nMiscompares;
  int          cyc;
  int          latency;
  int          nAccepted;
  int          nPops;
  logic [31:0] pendAddr [$];
  int          pendDue  [$];
  logic [31:0] expReqAddr;
  logic [31:0] expPc;
  logic        holdPending;
  logic [31:0] holdAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic reqReady, input logic instrReady,
                               input logic redirValid, input logic [31:0] redirPc);
    bus.imem_req_ready = reqReady;
    bus.instr_ready    = instrReady;
    bus.redirect_valid = redirValid;
    bus.redirect_pc    = redirPc;
  endtask

  task automatic settle();
    #1;
  endtask

  // Observe the settled cycle, clock it, then let the memory model drive the next cycle's response.
  task automatic tick();
    #1;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pendAddr.push_back(bus.imem_req_addr);
      pendDue.push_back(cyc + latency);
      nAccepted++;
    end
    if (bus.redirect_valid) begin
      checkOutput("redirReqValid", 32'(bus.imem_req_valid), 32'd0);
      checkOutput("redirInstrValid", 32'(bus.instr_valid), 32'd0);
      expReqAddr  = {bus.redirect_pc[31:2], 2'b00};
      expPc       = {bus.redirect_pc[31:2], 2'b00};
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("addrHold", bus.imem_req_addr, holdAddr);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        checkOutput("reqAddr", bus.imem_req_addr, expReqAddr);
        expReqAddr = expReqAddr + 32'd4;
      end
      holdPending = bus.imem_req_valid && !bus.imem_req_ready;
      holdAddr    = bus.imem_req_addr;
      if (bus.instr_valid && bus.instr_ready) begin
        checkOutput("instrPc", bus.instr_pc, expPc);
        checkOutput("instrData", bus.instruction, memWord(expPc));
        expPc = expPc + 32'd4;
        nPops++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (pendDue.size() > 0 && pendDue[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = memWord(pendAddr[0]);
      void'(pendAddr.pop_front());
      void'(pendDue.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'd0;
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'd0;
    pendAddr.delete();
    pendDue.delete();
    settle();
    checkOutput("rstReqValid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("rstInstrValid", 32'(bus.instr_valid), 32'd0);
    tick();
    tick();
    reset       = 1'b0;
    expReqAddr  = RESET_PC;
    expPc       = RESET_PC;
    holdPending = 1'b0;
    nAccepted   = 0;
    nPops       = 0;
    settle();
    checkOutput("rstAddr", bus.imem_req_addr, RESET_PC);
  endtask

  initial begin
    logic [31:0] rpc;
    nVectors     = 0;
    nMiscompares = 0;
    cyc          = 0;
    latency      = 1;
    holdPending  = 1'b0;
    holdAddr     = 32'd0;

    // Streaming at latency 1: first instruction two cycles after reset, then one per cycle.
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    settle();
    checkOutput("t1Addr0", bus.imem_req_addr, 32'h100);
    checkOutput("t1Valid0", 32'(bus.instr_valid), 32'd0);
    tick();
    settle();
    checkOutput("t1Addr1", bus.imem_req_addr, 32'h104);
    checkOutput("t1Valid1", 32'(bus.instr_valid), 32'd0);
    tick();
    settle();
    checkOutput("t1Valid2", 32'(bus.instr_valid), 32'd1);
    checkOutput("t1Pc2", bus.instr_pc, 32'h100);
    tick();
    for (int i = 0; i < 12; i++) begin
      settle();
      checkOutput("t1Stream", 32'(bus.instr_valid), 32'd1);
      tick();
    end

    // Decode stalled: the credit limit caps outstanding work at DEPTH.
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    settle();
    checkOutput("t2Accepted", 32'(nAccepted), 32'(DEPTH));
    checkOutput("t2Valid", 32'(bus.instr_valid), 32'd1);
    checkOutput("t2HeadPc", bus.instr_pc, 32'h100);
    checkOutput("t2ReqValid", 32'(bus.imem_req_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    settle();
    checkOutput("t2ReqResume", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("t2ReqAddr", bus.imem_req_addr, 32'h110);
    tick();
    settle();
    checkOutput("t2ReqFull1", 32'(bus.imem_req_valid), 32'd0);
    tick();
    settle();
    checkOutput("t2ReqFull2", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("t2HeadPc2", bus.instr_pc, 32'h104);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) tick();

    // Latency 3, redirect with two requests outstanding: both old words must be dropped.
    latency = 3;
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h2002);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    settle();
    checkOutput("t3ReqValid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("t3ReqAddr", bus.imem_req_addr, 32'h2000);
    checkOutput("t3Empty0", 32'(bus.instr_valid), 32'd0);
    tick();
    settle();
    checkOutput("t3ReqAddr1", bus.imem_req_addr, 32'h2004);
    checkOutput("t3Empty1", 32'(bus.instr_valid), 32'd0);
    tick();
    settle();
    checkOutput("t3Empty2", 32'(bus.instr_valid), 32'd0);
    tick();
    settle();
    checkOutput("t3Empty3", 32'(bus.instr_valid), 32'd0);
    tick();
    settle();
    checkOutput("t3FirstValid", 32'(bus.instr_valid), 32'd1);
    checkOutput("t3FirstPc", bus.instr_pc, 32'h2000);
    for (int i = 0; i < 10; i++) tick();

    // Redirect colliding with a response and a decode handshake.
    latency = 1;
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000);
    settle();
    checkOutput("t4InstrValid", 32'(bus.instr_valid), 32'd0);
    checkOutput("t4ReqValid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    settle();
    checkOutput("t4Empty", 32'(bus.instr_valid), 32'd0);
    checkOutput("t4ReqAddr", bus.imem_req_addr, 32'h3000);
    tick();
    settle();
    checkOutput("t4Empty2", 32'(bus.instr_valid), 32'd0);
    tick();
    settle();
    checkOutput("t4FirstValid", 32'(bus.instr_valid), 32'd1);
    checkOutput("t4FirstPc", bus.instr_pc, 32'h3000);
    for (int i = 0; i < 6; i++) tick();

    // Random memory back-pressure, decode stalls and occasional redirects at latency 2.
    latency = 2;
    applyReset();
    for (int i = 0; i < 300; i++) begin
      rpc = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 29) == 0), rpc);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t5Progress", 32'(nPops >= 40), 32'd1);

    // Address wrap at the top of the address space; misaligned redirect bits are ignored.
    latency = 1;
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFA);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    settle();
    checkOutput("t6Addr0", bus.imem_req_addr, 32'hFFFF_FFF8);
    tick();
    settle();
    checkOutput("t6Addr1", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    settle();
    checkOutput("t6Wrap", bus.imem_req_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("t6Delivered", 32'(nPops >= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule
